// File: rtl/volcado_memoria_datos_if.sv
// Handshake bundle linking the data-memory dump engine to memoria_datos (read port)
// and to the UART tx block; the engine itself uses the slave view.
interface volcado_memoria_datos_if #(
  parameter int RAM_WIDTH          = 32,
  parameter int ADDR_MEM_LENGTH    = 10,
  parameter int OUTPUT_WORD_LENGTH = 8
);
  logic                          start;
  logic [RAM_WIDTH-1:0]          data_mem;
  logic                          tx_done;
  logic [ADDR_MEM_LENGTH-1:0]    addr_mem;
  logic                          tx_start;
  logic [OUTPUT_WORD_LENGTH-1:0] data_tx;
  logic                          busy;
  logic                          done;

  modport master (
    output start, data_mem, tx_done,
    input  addr_mem, tx_start, data_tx, busy, done
  );

  modport slave (
    input  start, data_mem, tx_done,
    output addr_mem, tx_start, data_tx, busy, done
  );
endinterface

// File: rtl/volcado_memoria_datos.sv
// Streams data memory words 0..CANT_PALABRAS-1 to the UART tx, most significant byte
// first, one byte in flight at a time; pulses done after the last byte leaves tx.
module volcado_memoria_datos #(
  parameter int RAM_WIDTH          = 32,
  parameter int ADDR_MEM_LENGTH    = 10,
  parameter int OUTPUT_WORD_LENGTH = 8,
  parameter int CANT_PALABRAS      = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  volcado_memoria_datos_if.slave bus
);
  localparam int NB   = RAM_WIDTH / OUTPUT_WORD_LENGTH;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int WC_W = ADDR_MEM_LENGTH + 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NB - 1);
  // One extra bit so the full-depth case ends on the count, not on address wrap.
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(CANT_PALABRAS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                        state_r, state_s;
  logic [ADDR_MEM_LENGTH-1:0]    addr_r, addr_s;
  logic [OUTPUT_WORD_LENGTH-1:0] data_tx_r, data_tx_s;
  logic                          tx_start_r, tx_start_s;
  logic                          busy_r, busy_s;
  logic                          done_r, done_s;
  logic [RAM_WIDTH-1:0]          shift_r, shift_s;
  logic [BC_W-1:0]               byte_cnt_r, byte_cnt_s;
  logic [WC_W-1:0]               word_cnt_r, word_cnt_s;

  // Next-state and next-output decode; every output is computed here and registered below.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    data_tx_s  = data_tx_r;
    tx_start_s = 1'b0;
    shift_s    = shift_r;
    byte_cnt_s = byte_cnt_r;
    word_cnt_s = word_cnt_r;
    case (state_r)
      IDLE: begin
        addr_s     = '0;
        byte_cnt_s = '0;
        word_cnt_s = '0;
        if (bus.start) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        state_s = LATCH;
      end
      LATCH: begin
        shift_s    = bus.data_mem;
        data_tx_s  = bus.data_mem[RAM_WIDTH-1 -: OUTPUT_WORD_LENGTH];
        tx_start_s = 1'b1;
        byte_cnt_s = '0;
        state_s    = SEND;
      end
      SEND: begin
        state_s = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.tx_done) begin
          if (byte_cnt_r < LAST_BYTE) begin
            shift_s    = shift_r << OUTPUT_WORD_LENGTH;
            data_tx_s  = shift_s[RAM_WIDTH-1 -: OUTPUT_WORD_LENGTH];
            tx_start_s = 1'b1;
            byte_cnt_s = byte_cnt_r + BC_W'(1);
            state_s    = SEND;
          end else if (word_cnt_r < LAST_WORD) begin
            addr_s     = addr_r + ADDR_MEM_LENGTH'(1);
            word_cnt_s = word_cnt_r + WC_W'(1);
            state_s    = READ;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = WAIT_TX;
        end
      end
      DONE: begin
        addr_s  = '0;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State and registered outputs; reset returns everything to idle zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_r     <= '0;
      data_tx_r  <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      shift_r    <= '0;
      byte_cnt_r <= '0;
      word_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      data_tx_r  <= data_tx_s;
      tx_start_r <= tx_start_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      shift_r    <= shift_s;
      byte_cnt_r <= byte_cnt_s;
      word_cnt_r <= word_cnt_s;
    end
  end

  assign bus.addr_mem = addr_r;
  assign bus.data_tx  = data_tx_r;
  assign bus.tx_start = tx_start_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_volcado_memoria_datos.sv
// Directed bench: a 2-word instance with a slow tx model and a full-depth instance
// with a fast tx model, each fed by a synchronous memory model.
module tb_volcado_memoria_datos;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  volcado_memoria_datos_if #(.RAM_WIDTH(32), .ADDR_MEM_LENGTH(10), .OUTPUT_WORD_LENGTH(8)) if_s ();
  volcado_memoria_datos_if #(.RAM_WIDTH(32), .ADDR_MEM_LENGTH(10), .OUTPUT_WORD_LENGTH(8)) if_f ();

  volcado_memoria_datos #(.RAM_WIDTH(32), .ADDR_MEM_LENGTH(10), .OUTPUT_WORD_LENGTH(8),
                          .CANT_PALABRAS(2)) dut_small (.clk(clk), .rst(rst), .bus(if_s.slave));
  volcado_memoria_datos #(.RAM_WIDTH(32), .ADDR_MEM_LENGTH(10), .OUTPUT_WORD_LENGTH(8),
                          .CANT_PALABRAS(1024)) dut_full (.clk(clk), .rst(rst), .bus(if_f.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic spur_s = 1'b0;
  logic model_done_s, model_done_f;
  int   tx_cnt_s, tx_cnt_f;
  assign if_s.tx_done = model_done_s | spur_s;
  assign if_f.tx_done = model_done_f;

  logic [7:0] bytes_s[$];
  logic [7:0] bytes_f[$];
  logic [9:0] addr_f[$];
  int done_cnt_s = 0;
  int done_cnt_f = 0;
  logic [7:0] exp_bytes [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};

  // memoria_datos models: read data valid one cycle after the address
  always @(posedge clk) begin
    case (if_s.addr_mem)
      10'd0:   if_s.data_mem <= 32'hDEADBEEF;
      10'd1:   if_s.data_mem <= 32'h01234567;
      default: if_s.data_mem <= 32'hA5A5A5A5;
    endcase
    if_f.data_mem <= {22'd0, if_f.addr_mem};
  end

  // tx models: done pulse 20 (small) or 2 (full) cycles after seeing tx_start
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_s <= 0; model_done_s <= 1'b0; tx_cnt_f <= 0; model_done_f <= 1'b0;
    end else begin
      model_done_s <= 1'b0;
      model_done_f <= 1'b0;
      if (if_s.tx_start) tx_cnt_s <= 20;
      else if (tx_cnt_s != 0) begin
        tx_cnt_s <= tx_cnt_s - 1;
        if (tx_cnt_s == 1) model_done_s <= 1'b1;
      end
      if (if_f.tx_start) tx_cnt_f <= 2;
      else if (tx_cnt_f != 0) begin
        tx_cnt_f <= tx_cnt_f - 1;
        if (tx_cnt_f == 1) model_done_f <= 1'b1;
      end
    end
  end

  // byte / done monitors
  always @(posedge clk) begin
    if (if_s.tx_start) bytes_s.push_back(if_s.data_tx);
    if (if_s.done) done_cnt_s++;
    if (if_f.tx_start) begin bytes_f.push_back(if_f.data_tx); addr_f.push_back(if_f.addr_mem); end
    if (if_f.done) done_cnt_f++;
  end

  task automatic wait_done_s(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt_s > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done_f(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt_f > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; if_s.start = 1'b0; if_f.start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if_s.busy); end
    n_checks++; if (if_s.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", if_s.tx_start); end
    n_checks++; if (if_s.addr_mem !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 000", if_s.addr_mem); end
    n_checks++; if (if_s.data_tx !== 8'h00) begin n_fail++; $display("FAIL reset_data_tx: got %h want 00", if_s.data_tx); end
    n_checks++; if (if_s.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if_s.done); end
    rst = 1'b0;
    @(negedge clk);
    if_s.start = 1'b1; @(negedge clk); if_s.start = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b1 || if_s.data_tx !== 8'hDE) begin
      n_fail++; $display("FAIL midwait_state: got busy=%b data=%h want busy=1 data=de", if_s.busy, if_s.data_tx); end
    #2 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b0) begin n_fail++; $display("FAIL rst_wait_busy: got %b want 0", if_s.busy); end
    n_checks++; if (if_s.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_wait_tx_start: got %b want 0", if_s.tx_start); end
    n_checks++; if (if_s.addr_mem !== 10'd0) begin n_fail++; $display("FAIL rst_wait_addr: got %h want 000", if_s.addr_mem); end
    n_checks++; if (if_s.data_tx !== 8'h00) begin n_fail++; $display("FAIL rst_wait_data_tx: got %h want 00", if_s.data_tx); end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got busy=%b want 0", if_s.busy); end
  endtask

  task automatic test_latency;
    int bd; bit ok;
    bd = done_cnt_s;
    @(negedge clk); if_s.start = 1'b1;
    @(negedge clk); if_s.start = 1'b0;
    n_checks++; if (if_s.busy !== 1'b1 || if_s.tx_start !== 1'b0) begin
      n_fail++; $display("FAIL lat_e0: got busy=%b start=%b want 1/0", if_s.busy, if_s.tx_start); end
    @(negedge clk);
    n_checks++; if (if_s.tx_start !== 1'b0) begin n_fail++; $display("FAIL lat_e1: got tx_start=%b want 0", if_s.tx_start); end
    @(negedge clk);
    n_checks++; if (if_s.tx_start !== 1'b1 || if_s.data_tx !== 8'hDE) begin
      n_fail++; $display("FAIL lat_e2: got start=%b data=%h want 1/de", if_s.tx_start, if_s.data_tx); end
    @(negedge clk);
    n_checks++; if (if_s.tx_start !== 1'b0 || if_s.data_tx !== 8'hDE) begin
      n_fail++; $display("FAIL lat_e3: got start=%b data=%h want 0/de", if_s.tx_start, if_s.data_tx); end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (model_done_s) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lat_txdone_timeout: got 0 want 1"); end
    @(negedge clk);
    n_checks++; if (if_s.tx_start !== 1'b1 || if_s.data_tx !== 8'hAD) begin
      n_fail++; $display("FAIL lat_next_byte: got start=%b data=%h want 1/ad", if_s.tx_start, if_s.data_tx); end
    wait_done_s(bd, 1000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lat_done_timeout: got 0 want 1"); end
  endtask

  task automatic test_dump;
    int base, bd; bit ok;
    base = bytes_s.size(); bd = done_cnt_s;
    @(negedge clk); if_s.start = 1'b1;
    @(negedge clk); if_s.start = 1'b0;
    wait_done_s(bd, 1000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dump_timeout: got 0 want 1"); end
    n_checks++; if (bytes_s.size() - base !== 8) begin n_fail++; $display("FAIL dump_count: got %0d want 8", bytes_s.size() - base); end
    for (int i = 0; i < 8 && base + i < bytes_s.size(); i++) begin
      n_checks++; if (bytes_s[base+i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL dump_byte%0d: got %h want %h", i, bytes_s[base+i], exp_bytes[i]); end
    end
    n_checks++; if (done_cnt_s - bd !== 1) begin n_fail++; $display("FAIL dump_done_cnt: got %0d want 1", done_cnt_s - bd); end
    n_checks++; if (if_s.addr_mem !== 10'd0 || if_s.busy !== 1'b0) begin
      n_fail++; $display("FAIL dump_end_state: got addr=%h busy=%b want 000/0", if_s.addr_mem, if_s.busy); end
  endtask

  task automatic test_robustness;
    int base, bd; bit ok;
    base = bytes_s.size(); bd = done_cnt_s;
    @(negedge clk); spur_s = 1'b1;
    @(negedge clk); spur_s = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b0 || bytes_s.size() !== base) begin
      n_fail++; $display("FAIL idle_spurious: got busy=%b bytes=%0d want 0/%0d", if_s.busy, bytes_s.size(), base); end
    @(negedge clk); if_s.start = 1'b1;
    @(negedge clk); spur_s = 1'b1;
    @(negedge clk); spur_s = 1'b0;
    wait_done_s(bd, 1000, ok);
    if_s.start = 1'b0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rob_timeout: got 0 want 1"); end
    n_checks++; if (bytes_s.size() - base !== 8) begin n_fail++; $display("FAIL rob_count: got %0d want 8", bytes_s.size() - base); end
    for (int i = 0; i < 8 && base + i < bytes_s.size(); i++) begin
      n_checks++; if (bytes_s[base+i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL rob_byte%0d: got %h want %h", i, bytes_s[base+i], exp_bytes[i]); end
    end
    repeat (40) @(negedge clk);
    n_checks++; if (if_s.busy !== 1'b0 || bytes_s.size() - base !== 8 || done_cnt_s - bd !== 1) begin
      n_fail++; $display("FAIL rob_no_restart: got busy=%b bytes=%0d dones=%0d want 0/8/1",
                         if_s.busy, bytes_s.size() - base, done_cnt_s - bd); end
  endtask

  task automatic test_back_to_back;
    int base, bd; bit ok;
    base = bytes_s.size(); bd = done_cnt_s;
    @(negedge clk); if_s.start = 1'b1;
    @(negedge clk); if_s.start = 1'b0;
    wait_done_s(bd, 1000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_first_timeout: got 0 want 1"); end
    if_s.start = 1'b1;
    @(negedge clk); if_s.start = 1'b0;
    wait_done_s(bd + 1, 1000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_second_timeout: got 0 want 1"); end
    n_checks++; if (bytes_s.size() - base !== 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", bytes_s.size() - base); end
    for (int i = 0; i < 16 && base + i < bytes_s.size(); i++) begin
      n_checks++; if (bytes_s[base+i] !== exp_bytes[i % 8]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, bytes_s[base+i], exp_bytes[i % 8]); end
    end
    n_checks++; if (done_cnt_s - bd !== 2) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt_s - bd); end
  endtask

  task automatic test_full_depth;
    int base, bd, n; bit ok;
    logic [7:0] eb;
    base = bytes_f.size(); bd = done_cnt_f;
    @(negedge clk); if_f.start = 1'b1;
    @(negedge clk); if_f.start = 1'b0;
    wait_done_f(bd, 40000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_timeout: got 0 want 1"); end
    n = bytes_f.size() - base;
    n_checks++; if (n !== 4096) begin n_fail++; $display("FAIL full_count: got %0d want 4096", n); end
    for (int k = 0; k < n && k < 4096; k++) begin
      eb = 8'(((k / 4) >> (8 * (3 - (k % 4)))) & 255);
      n_checks++; if (bytes_f[base+k] !== eb || addr_f[base+k] !== 10'(k / 4)) begin
        n_fail++; $display("FAIL full_byte%0d: got %h@%h want %h@%h", k, bytes_f[base+k], addr_f[base+k], eb, 10'(k / 4)); end
    end
    if (n >= 4) begin
      n_checks++; if ({bytes_f[base+n-4], bytes_f[base+n-3], bytes_f[base+n-2], bytes_f[base+n-1]} !== 32'h000003FF) begin
        n_fail++; $display("FAIL full_last_word: got %h%h%h%h want 000003ff",
                           bytes_f[base+n-4], bytes_f[base+n-3], bytes_f[base+n-2], bytes_f[base+n-1]); end
      n_checks++; if (addr_f[base+n-1] !== 10'h3FF) begin n_fail++; $display("FAIL full_last_addr: got %h want 3ff", addr_f[base+n-1]); end
    end
    n_checks++; if (if_f.addr_mem !== 10'd0 || if_f.busy !== 1'b0 || done_cnt_f - bd !== 1) begin
      n_fail++; $display("FAIL full_end_state: got addr=%h busy=%b dones=%0d want 000/0/1",
                         if_f.addr_mem, if_f.busy, done_cnt_f - bd); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_dump;
    test_robustness;
    test_back_to_back;
    test_full_depth;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
